// File: rtl/write_full_ctrl_pkg.sv
// Shared FIFO helpers: Gray/binary conversion and default sizing constants.
// Used by both the write-side full controller and the read-side empty controller.
// The conversion functions work on a wide zero-extended vector, so any pointer width up to PTR_MAX works.
package fifo_pkg;

  localparam int FIFO_DEPTH  = 8;
  localparam int SYNC_STAGES = 2;
  localparam int PTR_MAX     = 32;

  // Reflected binary Gray code of a zero-extended pointer.
  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR from the MSB down.
  // Zero upper bits leave the result of a narrower pointer unchanged.
  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/write_full_ctrl_if.sv
// Bus between the write-pointer stage / read domain and the write-side full controller.
// Pointers are adr_width+1 bits; the MSB is the wrap bit.
// master drives pointers and requests; slave (the controller) returns status.
interface write_full_ctrl_if
  import fifo_pkg::*;
#(
  parameter int adr_width = $clog2(FIFO_DEPTH)
);

  logic [adr_width:0] write_adr;
  logic               wr_req;
  logic [adr_width:0] rd_ptr_gray;
  logic [adr_width:0] wr_ptr_gray;
  logic               FIFO_full;
  logic               almost_full;
  logic [adr_width:0] wr_level;
  logic               overflow_err;
  logic               ptr_err;

  modport master (
    output write_adr, wr_req, rd_ptr_gray,
    input  wr_ptr_gray, FIFO_full, almost_full, wr_level, overflow_err, ptr_err
  );

  modport slave (
    input  write_adr, wr_req, rd_ptr_gray,
    output wr_ptr_gray, FIFO_full, almost_full, wr_level, overflow_err, ptr_err
  );

endinterface

// File: rtl/write_full_ctrl_ptr_sync.sv
// Multi-flop synchronizer for a Gray pointer crossing clock domains.
// Latency: 'stages' clock edges from d_i to q_o.
// No backpressure; samples every edge.
module ptr_sync #(
  parameter int width  = 4,
  parameter int stages = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  logic [width-1:0] sync_q [stages];

  // Shift the pointer one flop per edge; all stages clear on reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < stages; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < stages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[stages-1];

endmodule

// File: rtl/write_full_ctrl.sv
// Write-domain full/level controller of the async FIFO; exports the Gray write pointer.
// Latency: full/level are combinational on write_adr; reads show up after sync_stages edges.
// Full is pessimistic (never deasserts early); writes while full set sticky overflow_err.
module write_full_ctrl
  import fifo_pkg::*;
#(
  parameter int depth       = FIFO_DEPTH,
  parameter int adr_width   = $clog2(depth),
  parameter int sync_stages = SYNC_STAGES,
  parameter int af_level    = depth - 2
) (
  input  logic               clk_w,
  input  logic               reset,
  write_full_ctrl_if.slave   bus
);

  localparam int             PW     = adr_width + 1;
  localparam logic [PW-1:0]  AF_LVL = PW'(af_level);

  logic [PW-1:0] rd_gray_s;
  logic [PW-1:0] rd_bin_s;
  logic [PW-1:0] rd_gray_q;
  logic [PW-1:0] wr_ptr_gray_q;
  logic [PW-1:0] wr_ptr_gray_d;
  logic [PW-1:0] wr_level_w;
  logic          full_w;
  logic          multi_bit_w;
  logic          chk_en_q;
  logic          overflow_q;
  logic          overflow_d;
  logic          ptr_err_q;
  logic          ptr_err_d;

  ptr_sync #(
    .width  (PW),
    .stages (sync_stages)
  ) u_rd_sync (
    .clk_i   (clk_w),
    .reset_i (reset),
    .d_i     (bus.rd_ptr_gray),
    .q_o     (rd_gray_s)
  );

  // Decode the synchronized read pointer and derive level/full against the write pointer.
  always_comb begin
    rd_bin_s      = PW'(gray2bin(PTR_MAX'(rd_gray_s)));
    wr_level_w    = bus.write_adr - rd_bin_s;
    full_w        = (bus.write_adr[adr_width] != rd_bin_s[adr_width]) &&
                    (bus.write_adr[adr_width-1:0] == rd_bin_s[adr_width-1:0]);
    multi_bit_w   = ($countones(rd_gray_s ^ rd_gray_q) > 1);
    wr_ptr_gray_d = PW'(bin2gray(PTR_MAX'(bus.write_adr)));
    overflow_d    = overflow_q | (bus.wr_req & full_w);
    ptr_err_d     = ptr_err_q | (chk_en_q & multi_bit_w);
  end

  // Registered Gray write pointer, previous read Gray pointer and sticky error flags.
  always_ff @(posedge clk_w or posedge reset) begin
    if (reset) begin
      wr_ptr_gray_q <= '0;
      rd_gray_q     <= '0;
      chk_en_q      <= 1'b0;
      overflow_q    <= 1'b0;
      ptr_err_q     <= 1'b0;
    end else begin
      wr_ptr_gray_q <= wr_ptr_gray_d;
      rd_gray_q     <= rd_gray_s;
      chk_en_q      <= 1'b1;
      overflow_q    <= overflow_d;
      ptr_err_q     <= ptr_err_d;
    end
  end

  // write_adr belongs to a neighbouring block whose reset may be skewed from ours,
  // so status derived from it is forced to zero while reset is held.
  assign bus.FIFO_full    = full_w & ~reset;
  assign bus.wr_level     = reset ? '0 : wr_level_w;
  assign bus.almost_full  = (wr_level_w >= AF_LVL) & ~reset;
  assign bus.wr_ptr_gray  = wr_ptr_gray_q;
  assign bus.overflow_err = overflow_q;
  assign bus.ptr_err      = ptr_err_q;

endmodule

// File: tb/tb_write_full_ctrl.sv
module tb_write_full_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int SYNC  = 2;
  localparam int AF    = 6;

  logic clk_w = 1'b0;
  logic reset;

  write_full_ctrl_if #(.adr_width(AW)) bus();

  write_full_ctrl #(
    .depth       (DEPTH),
    .adr_width   (AW),
    .sync_stages (SYNC),
    .af_level    (AF)
  ) dut (
    .clk_w (clk_w),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_w = ~clk_w;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] wa;
    logic [3:0] rb;
    logic [3:0] lvl;
    logic       full;
    logic       af;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] gray4(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  // Step to just after the next rising edge.
  task automatic step();
    @(posedge clk_w);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk_w);
    reset           = 1'b1;
    bus.write_adr   = '0;
    bus.wr_req      = 1'b0;
    bus.rd_ptr_gray = '0;
    @(negedge clk_w);
    reset = 1'b0;
    step();
  endtask

  // Random-traffic reference model state
  int          m_wa, m_wa_prev, m_rd, m_vis, m_vis_prev;
  int          m_lvl;
  logic        m_full, m_ovf, m_perr, acc, req, adv;
  int          rq[$];

  initial begin
    tbl[0]  = '{4'd0,  4'd0,  4'd0, 1'b0, 1'b0};
    tbl[1]  = '{4'd5,  4'd0,  4'd5, 1'b0, 1'b0};
    tbl[2]  = '{4'd6,  4'd0,  4'd6, 1'b0, 1'b1};
    tbl[3]  = '{4'd8,  4'd0,  4'd8, 1'b1, 1'b1};
    tbl[4]  = '{4'd9,  4'd1,  4'd8, 1'b1, 1'b1};
    tbl[5]  = '{4'd15, 4'd8,  4'd7, 1'b0, 1'b1};
    tbl[6]  = '{4'd0,  4'd8,  4'd8, 1'b1, 1'b1};
    tbl[7]  = '{4'd3,  4'd12, 4'd7, 1'b0, 1'b1};
    tbl[8]  = '{4'd2,  4'd13, 4'd5, 1'b0, 1'b0};
    tbl[9]  = '{4'd12, 4'd4,  4'd8, 1'b1, 1'b1};
    tbl[10] = '{4'd4,  4'd4,  4'd0, 1'b0, 1'b0};
    tbl[11] = '{4'd1,  4'd11, 4'd6, 1'b0, 1'b1};

    // ---- Reset with random inputs: every output zero
    reset           = 1'b1;
    bus.write_adr   = 4'($urandom);
    bus.wr_req      = 1'($urandom);
    bus.rd_ptr_gray = 4'($urandom);
    #3;
    chk("rst_wr_ptr_gray",  bus.wr_ptr_gray,  0);
    chk("rst_full",         bus.FIFO_full,    0);
    chk("rst_almost_full",  bus.almost_full,  0);
    chk("rst_wr_level",     bus.wr_level,     0);
    chk("rst_overflow",     bus.overflow_err, 0);
    chk("rst_ptr_err",      bus.ptr_err,      0);
    repeat (2) @(posedge clk_w);
    #2;
    chk("rst_held_level", bus.wr_level, 0);
    do_reset();

    // ---- Mid-fill reset
    bus.write_adr = 4'd5;
    repeat (SYNC + 1) step();
    chk("midfill_level", bus.wr_level, 5);
    reset = 1'b1;
    #1;
    chk("midfill_rst_level", bus.wr_level, 0);
    chk("midfill_rst_full",  bus.FIFO_full, 0);
    do_reset();

    // ---- Table-driven level/full/almost-full vectors (pointers held until settled)
    for (int i = 0; i < 12; i++) begin
      bus.write_adr   = tbl[i].wa;
      bus.rd_ptr_gray = gray4(int'(tbl[i].rb));
      repeat (SYNC + 1) step();
      chk($sformatf("tbl%0d_level", i), bus.wr_level,    tbl[i].lvl);
      chk($sformatf("tbl%0d_full", i),  bus.FIFO_full,   tbl[i].full);
      chk($sformatf("tbl%0d_af", i),    bus.almost_full, tbl[i].af);
    end
    do_reset();

    // ---- Fill 0..8 with read pointer at 0: same-cycle response
    for (int a = 0; a <= 8; a++) begin
      step();
      bus.write_adr = 4'(a);
      #1;
      chk($sformatf("fill%0d_level", a), bus.wr_level,    a);
      chk($sformatf("fill%0d_af", a),    bus.almost_full, (a >= AF) ? 1 : 0);
      chk($sformatf("fill%0d_full", a),  bus.FIFO_full,   (a == 8) ? 1 : 0);
    end

    // ---- Release from full: visible exactly SYNC edges later
    bus.rd_ptr_gray = gray4(1);
    step();
    chk("release_e1_full",  bus.FIFO_full, 1);
    chk("release_e1_level", bus.wr_level,  8);
    step();
    chk("release_e2_full",  bus.FIFO_full, 0);
    chk("release_e2_level", bus.wr_level,  7);

    // ---- Overflow: one-cycle wr_req while full, sticky until reset
    bus.write_adr = 4'd9;
    bus.wr_req    = 1'b1;
    #1;
    chk("ovf_full",   bus.FIFO_full,    1);
    chk("ovf_before", bus.overflow_err, 0);
    step();
    bus.wr_req = 1'b0;
    chk("ovf_set", bus.overflow_err, 1);
    repeat (4) step();
    chk("ovf_sticky", bus.overflow_err, 1);
    do_reset();
    chk("ovf_cleared", bus.overflow_err, 0);

    // ---- Wrap-around
    bus.write_adr   = 4'd14;
    bus.rd_ptr_gray = gray4(8);
    repeat (SYNC + 1) step();
    bus.write_adr = 4'd15;
    #1;
    chk("wrap15_level", bus.wr_level,  7);
    chk("wrap15_full",  bus.FIFO_full, 0);
    step();
    chk("wrap15_gray", bus.wr_ptr_gray, 4'b1000);
    bus.write_adr = 4'd0;
    #1;
    chk("wrap0_level",     bus.wr_level,    8);
    chk("wrap0_full",      bus.FIFO_full,   1);
    chk("wrap0_gray_lag",  bus.wr_ptr_gray, 4'b1000);
    step();
    chk("wrap0_gray", bus.wr_ptr_gray, 0);
    do_reset();

    // ---- Pointer check
    for (int i = 0; i <= 2; i++) begin
      bus.rd_ptr_gray = gray4(i);
      step();
    end
    repeat (SYNC + 1) step();
    chk("perr_legal_walk", bus.ptr_err, 0);
    // gray(2)=0011 and gray(5)=0111 differ in one bit, so this jump is not flagged.
    bus.rd_ptr_gray = gray4(5);
    repeat (SYNC + 2) step();
    chk("perr_2to5_onebit", bus.ptr_err, 0);
    bus.rd_ptr_gray = gray4(2);
    repeat (SYNC + 2) step();
    // gray(2)=0011 to gray(4)=0110 changes two bits.
    bus.rd_ptr_gray = gray4(4);
    repeat (SYNC) step();
    chk("perr_multibit_early", bus.ptr_err, 0);
    step();
    chk("perr_multibit_set", bus.ptr_err, 1);
    repeat (3) step();
    chk("perr_sticky", bus.ptr_err, 1);
    do_reset();
    chk("perr_cleared", bus.ptr_err, 0);
    for (int i = 0; i < 40; i++) begin
      bus.rd_ptr_gray = gray4(i);
      step();
    end
    repeat (SYNC + 1) step();
    chk("perr_full_sweep", bus.ptr_err, 0);
    do_reset();

    // ---- Random traffic against the occupancy model
    repeat (SYNC) step();
    m_wa = 0; m_wa_prev = 0; m_rd = 0; m_vis_prev = 0;
    m_ovf = 1'b0; m_perr = 1'b0; acc = 1'b0;
    rq.delete();
    for (int i = 0; i < SYNC; i++) rq.push_back(0);
    for (int n = 0; n < 300; n++) begin
      m_wa_prev = m_wa;
      if (acc) m_wa = (m_wa + 1) % 16;
      bus.write_adr = 4'(m_wa);
      #1;
      m_vis  = rq[0];
      m_lvl  = (m_wa - m_vis + 16) % 16;
      m_full = (m_lvl == DEPTH);
      if ($countones(gray4(m_vis) ^ gray4(m_vis_prev)) > 1) m_perr = 1'b1;
      m_vis_prev = m_vis;
      chk("rnd_level", bus.wr_level,     m_lvl);
      chk("rnd_full",  bus.FIFO_full,    m_full);
      chk("rnd_af",    bus.almost_full,  (m_lvl >= AF) ? 1 : 0);
      chk("rnd_gray",  bus.wr_ptr_gray,  gray4(m_wa_prev));
      chk("rnd_ovf",   bus.overflow_err, m_ovf);
      chk("rnd_perr",  bus.ptr_err,      m_perr);
      req = ($urandom_range(0, 99) < 60);
      acc = req && !m_full;
      if (req && m_full) m_ovf = 1'b1;
      bus.wr_req = req;
      adv = (m_rd != m_wa) && ($urandom_range(0, 99) < 40);
      if (adv) m_rd = (m_rd + 1) % 16;
      bus.rd_ptr_gray = gray4(m_rd);
      void'(rq.pop_front());
      rq.push_back(m_rd);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
